// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - set-mode sequencer for the 24-hour clock: field select, edit strobes, auto-repeat, blink mask
module time_set_ctrl #(
  parameter int REPEAT_DLY  = 5,
  parameter int REPEAT_RATE = 2,
  parameter int BLINK_HALF  = 5
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       SEL_MODE1,
  input  logic       BAP_BTN2,
  input  logic       BAP_BTN1,
  input  logic       BTN1_LVL,
  input  logic       CE_10HZ,
  output logic [1:0] SET_FIELD,
  output logic       RUN_EN,
  output logic       INC_HOUR,
  output logic       INC_MIN,
  output logic       CLR_SEC,
  output logic [2:0] BLINK_MASK
);

  // Repeat counter must hold the larger of the two repeat constants, never narrower than 4 bits.
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int REP_W   = ($clog2(REP_MAX + 1) > 4) ? $clog2(REP_MAX + 1) : 4;
  localparam int BLK_W   = ($clog2(BLINK_HALF) > 1) ? $clog2(BLINK_HALF) : 1;

  // A fire happens on the tick that would bring the count up to REPEAT_DLY.
  localparam logic [REP_W-1:0] REP_FIRE_AT = REP_W'(REPEAT_DLY - 1);
  localparam logic [REP_W-1:0] REP_RELOAD  = REP_W'(REPEAT_DLY - REPEAT_RATE);
  localparam logic [BLK_W-1:0] BLK_LAST    = BLK_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
  logic [BLK_W-1:0] blk_cnt, blk_cnt_nxt;
  logic             blk_phase, blk_phase_nxt;
  logic             state_chg;
  logic             rep_fire;
  logic             inc_evt;
  logic             inc_hour_nxt, inc_min_nxt, clr_sec_nxt;
  logic [2:0]       mask_nxt;

  // Next state, repeat/blink counters and the registered output values.
  always_comb begin
    state_nxt     = state;
    rep_cnt_nxt   = rep_cnt;
    rep_fire      = 1'b0;
    blk_cnt_nxt   = blk_cnt;
    blk_phase_nxt = blk_phase;
    mask_nxt      = 3'b000;

    // Dropping the mode permit aborts editing ahead of any field advance.
    if (state != RUN && !SEL_MODE1) begin
      state_nxt = RUN;
    end else if (BAP_BTN2) begin
      case (state)
        RUN:      if (SEL_MODE1) state_nxt = SET_HOUR;
        SET_HOUR: state_nxt = SET_MIN;
        SET_MIN:  state_nxt = SET_SEC;
        default:  state_nxt = RUN;
      endcase
    end
    state_chg = (state_nxt != state);

    if (state_chg || state == RUN || !BTN1_LVL) begin
      rep_cnt_nxt = '0;
    end else if (CE_10HZ) begin
      if (rep_cnt == REP_FIRE_AT) begin
        rep_fire    = 1'b1;
        rep_cnt_nxt = REP_RELOAD;
      end else begin
        rep_cnt_nxt = rep_cnt + 1'b1;
      end
    end

    // A field change swallows any increment in the same cycle; button and repeat merge into one strobe.
    inc_evt      = (BAP_BTN1 | rep_fire) & ~state_chg;
    inc_hour_nxt = inc_evt && (state == SET_HOUR);
    inc_min_nxt  = inc_evt && (state == SET_MIN);
    clr_sec_nxt  = inc_evt && (state == SET_SEC);

    // A freshly selected field always starts in the visible half.
    if (state_chg || state == RUN) begin
      blk_cnt_nxt   = '0;
      blk_phase_nxt = 1'b0;
    end else if (CE_10HZ) begin
      if (blk_cnt == BLK_LAST) begin
        blk_cnt_nxt   = '0;
        blk_phase_nxt = ~blk_phase;
      end else begin
        blk_cnt_nxt = blk_cnt + 1'b1;
      end
    end

    // Keep the field lit while it is being edited so the new value can be seen.
    if (blk_phase_nxt && !(inc_hour_nxt || inc_min_nxt || clr_sec_nxt)) begin
      case (state_nxt)
        SET_HOUR: mask_nxt = 3'b100;
        SET_MIN:  mask_nxt = 3'b010;
        SET_SEC:  mask_nxt = 3'b001;
        default:  mask_nxt = 3'b000;
      endcase
    end
  end

  // State, counters and all outputs register here; reset drops any edit in progress.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= RUN;
      rep_cnt    <= '0;
      blk_cnt    <= '0;
      blk_phase  <= 1'b0;
      RUN_EN     <= 1'b1;
      INC_HOUR   <= 1'b0;
      INC_MIN    <= 1'b0;
      CLR_SEC    <= 1'b0;
      BLINK_MASK <= 3'b000;
    end else begin
      state      <= state_nxt;
      rep_cnt    <= rep_cnt_nxt;
      blk_cnt    <= blk_cnt_nxt;
      blk_phase  <= blk_phase_nxt;
      RUN_EN     <= (state_nxt == RUN);
      INC_HOUR   <= inc_hour_nxt;
      INC_MIN    <= inc_min_nxt;
      CLR_SEC    <= clr_sec_nxt;
      BLINK_MASK <= mask_nxt;
    end
  end

  assign SET_FIELD = state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

  localparam int DLY  = 5;
  localparam int RATE = 2;
  localparam int HALF = 5;

  logic       CLK;
  logic       RESET_N;
  logic       SEL_MODE1;
  logic       BAP_BTN2;
  logic       BAP_BTN1;
  logic       BTN1_LVL;
  logic       CE_10HZ;
  logic [1:0] SET_FIELD;
  logic       RUN_EN;
  logic       INC_HOUR;
  logic       INC_MIN;
  logic       CLR_SEC;
  logic [2:0] BLINK_MASK;

  time_set_ctrl #(
    .REPEAT_DLY (DLY),
    .REPEAT_RATE(RATE),
    .BLINK_HALF (HALF)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .SEL_MODE1 (SEL_MODE1),
    .BAP_BTN2  (BAP_BTN2),
    .BAP_BTN1  (BAP_BTN1),
    .BTN1_LVL  (BTN1_LVL),
    .CE_10HZ   (CE_10HZ),
    .SET_FIELD (SET_FIELD),
    .RUN_EN    (RUN_EN),
    .INC_HOUR  (INC_HOUR),
    .INC_MIN   (INC_MIN),
    .CLR_SEC   (CLR_SEC),
    .BLINK_MASK(BLINK_MASK)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 0;
  int cnt_h     = 0;
  int cnt_m     = 0;
  int cnt_s     = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: field index 0..3, ticks held since the hold began, ticks since the field was entered.
  int         m_field = 0;
  int         held    = 0;
  int         bticks  = 0;
  int         nf;
  bit         m_chg, m_fire, m_ev;
  logic [1:0] exp_field;
  logic       exp_run_en, exp_h, exp_m, exp_s;
  logic [2:0] exp_mask;

  always @(posedge CLK) begin
    if (!RESET_N) begin
      m_field = 0; held = 0; bticks = 0;
      exp_field = 2'b00; exp_run_en = 1'b1;
      exp_h = 1'b0; exp_m = 1'b0; exp_s = 1'b0; exp_mask = 3'b000;
    end else begin
      nf = m_field;
      if (m_field != 0 && !SEL_MODE1) nf = 0;
      else if (BAP_BTN2 && (m_field != 0 || SEL_MODE1)) nf = (m_field + 1) % 4;
      m_chg  = (nf != m_field);
      m_fire = 1'b0;
      if (m_chg || m_field == 0 || !BTN1_LVL) held = 0;
      else if (CE_10HZ) begin
        held++;
        m_fire = (held >= DLY) && (((held - DLY) % RATE) == 0);
      end
      if (m_chg) bticks = 0;
      else if (CE_10HZ) bticks++;
      m_ev  = (BAP_BTN1 || m_fire) && !m_chg && m_field != 0;
      exp_h = m_ev && m_field == 1;
      exp_m = m_ev && m_field == 2;
      exp_s = m_ev && m_field == 3;
      if (m_ev || nf == 0 || ((bticks / HALF) % 2) == 0) exp_mask = 3'b000;
      else exp_mask = 3'b100 >> (nf - 1);
      m_field    = nf;
      exp_field  = nf[1:0];
      exp_run_en = (nf == 0);
    end
  end

  // Every-cycle comparison against the model, plus strobe tallies.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("SET_FIELD", SET_FIELD, exp_field);
      chk("RUN_EN", RUN_EN, exp_run_en);
      chk("INC_HOUR", INC_HOUR, exp_h);
      chk("INC_MIN", INC_MIN, exp_m);
      chk("CLR_SEC", CLR_SEC, exp_s);
      chk("BLINK_MASK", BLINK_MASK, exp_mask);
    end
    cnt_h += INC_HOUR;
    cnt_m += INC_MIN;
    cnt_s += CLR_SEC;
  end

  task automatic tick(input bit b2, input bit b1, input bit ce);
    BAP_BTN2 = b2; BAP_BTN1 = b1; CE_10HZ = ce;
    @(posedge CLK); #2;
    BAP_BTN2 = 1'b0; BAP_BTN1 = 1'b0; CE_10HZ = 1'b0;
  endtask

  task automatic clr_counts();
    cnt_h = 0; cnt_m = 0; cnt_s = 0;
  endtask

  initial begin
    // Reset held with mode permit and all buttons active.
    RESET_N = 1'b0; SEL_MODE1 = 1'b1; BAP_BTN2 = 1'b1; BAP_BTN1 = 1'b1;
    BTN1_LVL = 1'b1; CE_10HZ = 1'b1;
    repeat (3) @(posedge CLK);
    #2;
    chk_en = 1'b1;
    chk("rst field", SET_FIELD, 2'b00);
    chk("rst run_en", RUN_EN, 1'b1);
    chk("rst strobes", {INC_HOUR, INC_MIN, CLR_SEC}, 3'b000);
    chk("rst mask", BLINK_MASK, 3'b000);
    BAP_BTN2 = 1'b0; BAP_BTN1 = 1'b0; CE_10HZ = 1'b0; BTN1_LVL = 1'b0;
    RESET_N = 1'b1;
    tick(0, 0, 0);

    // Field sequencing through all four states.
    for (int i = 1; i <= 4; i++) begin
      tick(1, 0, 0);
      chk("seq field", SET_FIELD, i % 4);
      chk("seq run_en", RUN_EN, (i == 4));
    end

    // Single increments in SET_MIN, SET_SEC, and ignored in RUN.
    tick(1, 0, 0);
    tick(1, 0, 0);
    clr_counts();
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0);
      chk("min strobe hi", INC_MIN, 1'b1);
      tick(0, 0, 0);
      chk("min strobe lo", INC_MIN, 1'b0);
    end
    chk("min count", cnt_m, 3);
    chk("min no hour", cnt_h, 0);
    chk("min no sec", cnt_s, 0);
    tick(1, 0, 0);
    clr_counts();
    tick(0, 1, 0);
    tick(0, 0, 0);
    chk("sec count", cnt_s, 1);
    chk("sec others", cnt_h + cnt_m, 0);
    tick(1, 0, 0);
    clr_counts();
    tick(0, 1, 0);
    tick(0, 0, 0);
    chk("run no strobe", cnt_h + cnt_m + cnt_s, 0);

    // Auto-repeat in SET_HOUR with button held for 12 ticks.
    tick(1, 0, 0);
    chk("hour field", SET_FIELD, 2'b01);
    clr_counts();
    BTN1_LVL = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick(0, 0, 1);
      chk("repeat strobe", INC_HOUR, (t == 5 || t == 7 || t == 9 || t == 11));
      tick(0, 0, 0);
    end
    chk("repeat count", cnt_h, 4);
    BTN1_LVL = 1'b0;
    tick(0, 0, 0);
    BTN1_LVL = 1'b1;
    clr_counts();
    for (int t = 1; t <= 6; t++) begin
      tick(0, 0, 1);
      chk("rehold strobe", INC_HOUR, (t == 5));
      tick(0, 0, 0);
    end
    chk("rehold count", cnt_h, 1);
    BTN1_LVL = 1'b0;

    // Field advance beats a simultaneous increment.
    tick(1, 1, 0);
    chk("prio field", SET_FIELD, 2'b10);
    chk("prio strobes", {INC_HOUR, INC_MIN}, 2'b00);

    // Mode permit drops in SET_MIN while a repeat is about to fire.
    BTN1_LVL = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick(0, 0, 1);
      tick(0, 0, 0);
    end
    clr_counts();
    SEL_MODE1 = 1'b0;
    tick(0, 0, 1);
    chk("abort field", SET_FIELD, 2'b00);
    chk("abort run_en", RUN_EN, 1'b1);
    for (int t = 0; t < 4; t++) tick(0, 0, 1);
    chk("abort strobes", cnt_h + cnt_m + cnt_s, 0);
    BTN1_LVL = 1'b0;
    SEL_MODE1 = 1'b1;

    // Blink in SET_HOUR, then a strobe during the blanked half.
    tick(1, 0, 0);
    chk("blink start", BLINK_MASK, 3'b000);
    for (int t = 1; t <= 25; t++) begin
      tick(0, 0, 1);
      chk("blink mask", BLINK_MASK, ((t / 5) % 2) ? 3'b100 : 3'b000);
      tick(0, 0, 0);
    end
    tick(0, 1, 0);
    chk("blink strobe mask", BLINK_MASK, 3'b000);
    chk("blink strobe", INC_HOUR, 1'b1);
    tick(0, 0, 0);
    chk("blink after strobe", BLINK_MASK, 3'b100);

    tick(0, 0, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
